// File: rtl/mux_n1_scan.sv
// Registered N:1 channel multiplexer with a tri-state output bus. It has a manual-select
// mode and an auto-scan mode that round-robins the channels with a programmable dwell time.
module mux_n1_scan #(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int SW = $clog2(N),
    parameter int DW = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [N*W-1:0]  IN,
    input  logic [SW-1:0]   Sel,
    input  logic            ENA,
    input  logic            MODE,
    input  logic [DW-1:0]   DWELL,
    output logic [W-1:0]    Output,
    output logic            Valid,
    output logic [SW-1:0]   Chan,
    output logic            Wrap,
    output logic [1:0]      o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam int              LP_NP   = 1 << SW;
    localparam logic [SW:0]     LP_N    = (SW+1)'(N);
    localparam logic [SW-1:0]   LP_LAST = SW'(N-1);

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_out, w_out_nxt;
    logic            r_valid, w_valid_nxt;
    logic [SW-1:0]   r_chan, w_chan_nxt;
    logic            r_wrap, w_wrap_nxt;
    logic [SW-1:0]   r_idx, w_idx_nxt;
    logic [DW-1:0]   r_cnt, w_cnt_nxt;
    logic [DW-1:0]   r_dwell, w_dwell_nxt;

    // Pad the channel table to a power of two so any Sel value indexes safely.
    logic [W-1:0]    w_ch [LP_NP];
    logic            w_sel_ok;
    logic [SW-1:0]   w_idx_inc;

    for (genvar c = 0; c < LP_NP; c++) begin : g_ch
        if (c < N) begin : g_real
            assign w_ch[c] = IN[c*W +: W];
        end else begin : g_pad
            assign w_ch[c] = '0;
        end
    end

    assign w_sel_ok  = ({1'b0, Sel} < LP_N);
    assign w_idx_inc = (r_idx == LP_LAST) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_valid_nxt = r_valid;
        w_chan_nxt  = r_chan;
        w_wrap_nxt  = 1'b0;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_dwell_nxt = r_dwell;

        if (!ENA) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else if (!MODE) begin
            // Leaving scan discards its position; re-entry restarts at channel 0.
            w_state_nxt = ST_MANUAL;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            if (w_sel_ok) begin
                w_out_nxt   = w_ch[Sel];
                w_chan_nxt  = Sel;
                w_valid_nxt = 1'b1;
            end else begin
                w_valid_nxt = 1'b0;
            end
        end else if (r_state != ST_SCAN) begin
            w_state_nxt = ST_SCAN;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_dwell_nxt = DWELL;
            w_out_nxt   = w_ch[0];
            w_chan_nxt  = '0;
            w_valid_nxt = 1'b1;
        end else begin
            w_state_nxt = ST_SCAN;
            w_valid_nxt = 1'b1;
            if (r_cnt == r_dwell) begin
                w_idx_nxt   = w_idx_inc;
                w_cnt_nxt   = '0;
                w_dwell_nxt = DWELL;
                w_wrap_nxt  = (r_idx == LP_LAST);
            end else begin
                w_cnt_nxt   = r_cnt + 1'b1;
            end
            w_out_nxt  = w_ch[w_idx_nxt];
            w_chan_nxt = w_idx_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_chan  <= '0;
            r_wrap  <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_chan  <= w_chan_nxt;
            r_wrap  <= w_wrap_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dwell <= w_dwell_nxt;
        end
    end

    assign Output      = r_valid ? r_out : {W{1'bz}};
    assign Valid       = r_valid;
    assign Chan        = r_chan;
    assign Wrap        = r_wrap;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_n1_scan.sv
// Bench for mux_n1_scan: an 8x1 instance and a 5x4 instance run side by side.
// A behavioural model is compared every cycle, and directed literal checks are made at key points.
module tb_mux_n1_scan;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic        ENA   = 1'b0;
    logic        MODE  = 1'b0;
    logic [7:0]  DWELL = '0;
    logic [7:0]  in_a  = '0;
    logic [2:0]  sel_a = '0;
    logic [19:0] in_b  = '0;
    logic [2:0]  sel_b = '0;
    wire  [0:0]  out_a;
    wire  [3:0]  out_b;
    logic        valid_a, valid_b, wrap_a, wrap_b;
    logic [2:0]  chan_a, chan_b;
    logic [1:0]  st_a, st_b;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mux_n1_scan #(.N(8), .W(1), .DW(8)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .IN(in_a), .Sel(sel_a), .ENA(ENA), .MODE(MODE),
        .DWELL(DWELL), .Output(out_a), .Valid(valid_a), .Chan(chan_a), .Wrap(wrap_a),
        .o_dbg_state(st_a)
    );

    mux_n1_scan #(.N(5), .W(4), .DW(8)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .IN(in_b), .Sel(sel_b), .ENA(ENA), .MODE(MODE),
        .DWELL(DWELL), .Output(out_b), .Valid(valid_b), .Chan(chan_b), .Wrap(wrap_b),
        .o_dbg_state(st_b)
    );

    // st: 0 idle, 1 manual, 2 scan. left = cycles still to show the current scan channel.
    typedef struct {
        int          st;
        int          ch;
        int          left;
        int          chan;
        bit          valid;
        bit          wrap;
        logic [63:0] out;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.st = 0; m.ch = 0; m.left = 0; m.chan = 0;
        m.valid = 1'b0; m.wrap = 1'b0; m.out = '0;
        return m;
    endfunction

    function automatic logic [63:0] field(logic [63:0] in, int k, int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (in >> (k * w)) & mask;
    endfunction

    function automatic model_t model_step(model_t m, int n, int w, bit ena, bit mode,
                                          int sel, int dwell, logic [63:0] in);
        model_t r;
        r = m;
        r.wrap = 1'b0;
        if (!ena) begin
            r.st = 0;
            r.valid = 1'b0;
        end else if (!mode) begin
            r.st = 1;
            if (sel < n) begin
                r.valid = 1'b1;
                r.chan  = sel;
                r.out   = field(in, sel, w);
            end else begin
                r.valid = 1'b0;
            end
        end else if (m.st != 2) begin
            r.st = 2; r.ch = 0; r.left = dwell; r.chan = 0;
            r.valid = 1'b1;
            r.out = field(in, 0, w);
        end else begin
            if (m.left == 0) begin
                r.ch   = (m.ch + 1) % n;
                r.left = dwell;
                r.wrap = (r.ch == 0);
            end else begin
                r.left = m.left - 1;
            end
            r.chan  = r.ch;
            r.valid = 1'b1;
            r.out   = field(in, r.ch, w);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    model_t ma = model_reset();
    model_t mb = model_reset();

    always @(posedge CLK) begin
        if (!RST_N) begin
            ma = model_reset();
            mb = model_reset();
        end else begin
            ma = model_step(ma, 8, 1, ENA, MODE, int'(sel_a), int'(DWELL), 64'(in_a));
            mb = model_step(mb, 5, 4, ENA, MODE, int'(sel_b), int'(DWELL), 64'(in_b));
        end
        #1;
        chk("a_valid", 64'(valid_a), 64'(ma.valid));
        chk("a_chan",  64'(chan_a),  64'(ma.chan));
        chk("a_wrap",  64'(wrap_a),  64'(ma.wrap));
        chk("a_state", 64'(st_a),    64'(ma.st));
        if (ma.valid) chk("a_out", 64'(out_a), ma.out);
        chk("b_valid", 64'(valid_b), 64'(mb.valid));
        chk("b_chan",  64'(chan_b),  64'(mb.chan));
        chk("b_wrap",  64'(wrap_b),  64'(mb.wrap));
        chk("b_state", 64'(st_b),    64'(mb.st));
        if (mb.valid) chk("b_out", 64'(out_b), mb.out);
    end

    // Inputs change 2 time units after the rising edge, clear of the model/compare sample.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        bit pat [8] = '{0, 1, 0, 1, 0, 0, 1, 1};
        int exp_ch;

        // Reset
        tick(); tick();
        chk("rst_valid_a", 64'(valid_a), 64'd0);
        chk("rst_chan_a",  64'(chan_a),  64'd0);
        RST_N = 1'b1;
        tick();

        // Manual select walk; instance B hits out-of-range selects 5..7
        ENA = 1'b1; MODE = 1'b0; in_a = 8'hAA; in_b = 20'($urandom);
        for (int s = 0; s < 8; s++) begin
            sel_a = 3'(s); sel_b = 3'(s);
            tick();
            chk("t1_out",  64'(out_a),   64'(s % 2));
            chk("t1_chan", 64'(chan_a),  64'(s));
            chk("t1_vld",  64'(valid_a), 64'd1);
            if (s == 4) chk("t6_out4",  64'(out_b),   64'(in_b[19:16]));
            if (s == 6) chk("t6_vld6",  64'(valid_b), 64'd0);
            if (s == 6) chk("t6_chan6", 64'(chan_b),  64'd4);
        end

        // Scan with DWELL=2
        MODE = 1'b1; DWELL = 8'd2;
        for (int i = 0; i < 26; i++) begin
            tick();
            chk("t3_chan", 64'(chan_a), 64'((i / 3) % 8));
            chk("t3_wrap", 64'(wrap_a), 64'(i == 24));
        end

        // Disable, then DWELL=0 scan pattern
        ENA = 1'b0;
        tick();
        chk("t2_dis_vld", 64'(valid_a), 64'd0);
        ENA = 1'b1; DWELL = 8'd0; in_a = 8'b1100_1010;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk("t4_out",  64'(out_a),  64'(pat[i % 8]));
            chk("t4_wrap", 64'(wrap_a), 64'((i % 8 == 0) && (i > 0)));
        end

        // Mid-dwell DWELL change: channel 2 keeps its 4-cycle dwell
        ENA = 1'b0;
        tick();
        ENA = 1'b1; DWELL = 8'd3;
        for (int i = 0; i < 15; i++) begin
            if (i == 9) DWELL = 8'd0;
            tick();
            exp_ch = (i <= 11) ? i / 4 : i - 9;
            chk("t5_chan", 64'(chan_a), 64'(exp_ch));
        end
        MODE = 1'b0; sel_a = 3'd5;
        tick();
        chk("t5_man5", 64'(chan_a), 64'd5);
        MODE = 1'b1;
        tick();
        chk("t5_re0",   64'(chan_a), 64'd0);
        chk("t5_rewrp", 64'(wrap_a), 64'd0);
        tick(); tick();
        chk("t2_pre_ch", 64'(chan_a), 64'd2);

        // Asynchronous reset between edges
        RST_N = 1'b0;
        #2;
        chk("t2_arst_vld",  64'(valid_a), 64'd0);
        chk("t2_arst_chan", 64'(chan_a),  64'd0);
        chk("t2_arst_wrap", 64'(wrap_a),  64'd0);
        chk("t2_arst_chb",  64'(chan_b),  64'd0);
        tick();
        RST_N = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            ENA   = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 29) == 0) MODE = ~MODE;
            DWELL = 8'($urandom_range(0, 2));
            in_a  = 8'($urandom);
            in_b  = 20'($urandom);
            sel_a = 3'($urandom_range(0, 7));
            sel_b = 3'($urandom_range(0, 7));
            RST_N = ($urandom_range(0, 79) != 0);
            tick();
        end
        RST_N = 1'b1;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
